// File: rtl/sequence_checker_if.sv
// Symbol stream and status bundle between the sequence generator side and sequence_checker.
interface sequence_checker_if #(
  parameter int unsigned CNT_WIDTH = 16
) ();
  logic                 enable;
  logic [7:0]           data;
  logic                 clear;
  logic                 locked;
  logic                 error;
  logic [CNT_WIDTH-1:0] error_count;
  logic [2:0]           exp_index;

  modport master (
    output enable, data, clear,
    input  locked, error, error_count, exp_index
  );

  modport slave (
    input  enable, data, clear,
    output locked, error, error_count, exp_index
  );
endinterface

// File: rtl/sequence_checker.sv
// Hunts for the AF start symbol, verifies the 8-entry cycle, then tracks lock and symbol errors.
// Error counter and clear are built only when SEQUENCE_CHECKER_ERR_CNT_EN is defined.
module sequence_checker #(
  parameter int unsigned LOCK_COUNT = 8,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic               clock,
  input logic               reset_n,
  sequence_checker_if.slave bus
);

  localparam logic [7:0] StartSym = 8'hAF;
  localparam logic [7:0] LockThr  = 8'(LOCK_COUNT);
  localparam logic [7:0] LossThr  = 8'(LOSS_COUNT);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e     state_q;
  logic [2:0] idx_q;
  logic [7:0] run_q;
  logic [7:0] miss_q;
  logic       locked_q;
  logic       error_q;

  function automatic logic [7:0] exp_sym(logic [2:0] idx);
    case (idx)
      3'd0:    exp_sym = 8'hAF;
      3'd1:    exp_sym = 8'hBC;
      3'd2:    exp_sym = 8'hE2;
      3'd3:    exp_sym = 8'h78;
      3'd4:    exp_sym = 8'hFF;
      3'd5:    exp_sym = 8'hE2;
      3'd6:    exp_sym = 8'h0B;
      default: exp_sym = 8'h8D;
    endcase
  endfunction

  logic       sym_match;
  logic       is_start;
  logic [7:0] run_inc;
  logic [7:0] miss_inc;

  assign sym_match = (bus.data == exp_sym(idx_q));
  assign is_start  = (bus.data == StartSym);
  assign run_inc   = run_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StHunt;
      idx_q    <= 3'd0;
      run_q    <= 8'd0;
      miss_q   <= 8'd0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      if (bus.enable) begin
        unique case (state_q)
          StHunt: begin
            if (is_start) begin
              idx_q  <= 3'd1;
              run_q  <= 8'd1;
              miss_q <= 8'd0;
              if (LockThr == 8'd1) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end else begin
                state_q <= StVerify;
              end
            end else begin
              idx_q <= 3'd0;
            end
          end
          StVerify: begin
            if (sym_match) begin
              run_q <= run_inc;
              idx_q <= idx_q + 3'd1;
              if (run_inc >= LockThr) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
                miss_q   <= 8'd0;
              end
            end else if (is_start) begin
              // The offending symbol is itself a fresh anchor.
              idx_q <= 3'd1;
              run_q <= 8'd1;
            end else begin
              state_q <= StHunt;
              idx_q   <= 3'd0;
              run_q   <= 8'd0;
            end
          end
          StLocked: begin
            idx_q <= idx_q + 3'd1;
            if (sym_match) begin
              miss_q <= 8'd0;
            end else begin
              error_q <= 1'b1;
              miss_q  <= miss_inc;
              if (miss_inc >= LossThr) begin
                state_q  <= StHunt;
                locked_q <= 1'b0;
                idx_q    <= 3'd0;
                run_q    <= 8'd0;
                miss_q   <= 8'd0;
              end
            end
          end
          default: begin
            state_q  <= StHunt;
            locked_q <= 1'b0;
            idx_q    <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.error     = error_q;
  assign bus.exp_index = idx_q;

`ifdef SEQUENCE_CHECKER_ERR_CNT_EN
  logic                 miss_hit;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign miss_hit = bus.enable && (state_q == StLocked) && !sym_match;

  // Clear wins over a simultaneous increment; count saturates at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bus.clear) begin
      cnt_q <= '0;
    end else if (miss_hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.error_count = cnt_q;
`else
  assign bus.error_count = '0;
`endif

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Downstream consumer of the 8-bit sequence generator stream. Samples one symbol per enabled clock edge and hunts for the start symbol 8'hAF. It then verifies alignment against the fixed 8-entry cycle and declares lock. Once locked it flags and counts mismatching symbols, and drops lock after a run of consecutive misses. It sits directly on the generator's `data`/`enable` pair and feeds status to the test/monitor logic.

## Interface
- `LOCK_COUNT`, default 8: consecutive matching symbols, counting the AF, required to enter LOCKED; legal range 1..255.
- `LOSS_COUNT`, default 4: consecutive mismatches in LOCKED that cause loss of lock; legal range 1..255.
- `CNT_WIDTH`, default 16: width of `error_count`; legal range 2..32.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  symbol qualifier; `data` is one symbol on each rising edge where `enable`=1 (same signal that advances the generator).
- `data`  in  8  symbol from the generator.
- `clear`  in  1  synchronous clear of `error_count`.
- `locked`  out  1  high while in LOCKED.
- `error`  out  1  one-cycle pulse per mismatching symbol while LOCKED.
- `error_count`  out  CNT_WIDTH  saturating mismatch count.
- `exp_index`  out  3  index of the next expected symbol.

## Operation
- Expected cycle, by index 0..7: AF, BC, E2, 78, FF, E2, 0B, 8D. `exp_index` wraps from 7 to 0.
- AF occurs only at index 0 and is the sole hunt anchor.
- The E2 duplicate at indices 2 and 5 is resolved by the index, not by value.

States:
- **HUNT**: a sample equal to AF goes to VERIFY with `exp_index`=1 and run=1. If run=1 already meets `LOCK_COUNT` (`LOCK_COUNT`=1), go directly to LOCKED. Any other sample keeps the block in HUNT with `exp_index`=0.
- **VERIFY**: a match increments run and advances `exp_index`. When run reaches `LOCK_COUNT`, go to LOCKED.
- **VERIFY mismatch**: return to HUNT with `exp_index`=0. If that same mismatching sample is AF, re-enter VERIFY with `exp_index`=1 and run=1.
- **VERIFY errors**: no `error` pulse and no count in VERIFY.
- **LOCKED match**: advance `exp_index` and reset miss_run to 0.
- **LOCKED mismatch**:
  - advance `exp_index` regardless;
  - pulse `error`;
  - increment `error_count`, saturating at all-ones;
  - increment miss_run.
- **Loss of lock**: when miss_run reaches `LOSS_COUNT`, go to HUNT with `exp_index`=0. `error` still pulses for that final miss.
- **`enable`=0**: no state, index, run or count changes. `error` is 0.
- **`clear`=1**: `error_count` becomes 0 on that edge and wins over a simultaneous increment. It does not affect state or lock.
- **Reset (any time, including mid-lock)**: state HUNT, `locked`=0, `error`=0, `error_count`=0, `exp_index`=0, all runs 0.

## Timing
- All outputs are registered. A sample taken at edge N is reflected on the outputs after edge N.
- Zero combinational paths from inputs to outputs.
- `locked` rises after the edge that samples the `LOCK_COUNT`-th consecutive match. With default parameters and an aligned stream from reset, that is the 8th enabled edge.
- `locked` falls after the edge that samples the `LOSS_COUNT`-th consecutive miss.
- `error` is high for exactly one cycle per offending enabled edge. Back-to-back misses give continuous high.
- Reset assertion clears outputs immediately, without waiting for a clock edge. Deassertion takes effect at the next rising edge.

## Configuration
- `SEQUENCE_CHECKER_ERR_CNT_EN`, defined: the `error_count` register, its saturation and `clear` are implemented as above.
- `SEQUENCE_CHECKER_ERR_CNT_EN`, undefined:
  - `error_count` is tied to 0;
  - `clear` is ignored;
  - no counter flops are synthesized;
  - `error`, `locked` and lock/loss behaviour are unchanged.

## Test plan
- **Lock from reset:** reset, then 16 enabled edges of the aligned sequence from AF (defaults) -> `locked`=1 after the 8th edge; `error` never high; `error_count`=0; `exp_index`=0 after the 16th.
- **Single corrupt symbol:** while locked, 8'h00 in place of 78 -> `error` high exactly one cycle; `error_count`=1; `locked` stays 1; following symbols produce no error.
- **Loss and relock:** while locked, 4 consecutive corrupt symbols -> `error_count`=4; `locked` falls after the 4th. The aligned stream then resumes from AF -> relock after 8 more matches.
- **Enable gating:** while locked, `enable`=0 for 8 cycles with `data` toggling random values -> `locked`, `exp_index`, `error_count` unchanged; `error`=0.
- **VERIFY mismatch:** AF, BC, E2, 78, FF, then 8'h11 -> back to HUNT; `locked`=0; no `error`; `error_count`=0. A following AF re-enters VERIFY with `exp_index`=1.
- **Saturation and clear:** `CNT_WIDTH`=4, `LOSS_COUNT`=255, locked, 20 mismatches -> `error_count` sticks at 15. `clear`=1 on the same edge as a mismatch -> `error_count`=0 and `error` pulses.
- **Reset mid-lock:** `reset_n` pulsed low mid-lock -> all outputs zero without waiting for a clock edge.
